// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
//
// Time-multiplexes DIGITS BCD nibbles onto a common-anode seven-segment
// display. One digit is driven at a time. The selection advances every
// SCAN_DIV cycles of CP. Digit data, the decimal-point mask and EN are
// sampled only when the scan advances, so a counter carry that lands in the
// middle of a slot cannot tear the digit being shown.
//
// Optional feature: define SEG_BLINK_EN to build a blink phase generator.
// Digits selected by blink_mask then have their content blanked during
// every odd blink phase. Their anode stays asserted.
//
// Ports:
//   CP          system clock; all logic is on posedge CP
//   reset       synchronous, active-high reset
//   EN          display enable; 0 blanks the display, scanning continues
//   digits      BCD nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_mask     1 = light the decimal point of digit i
//   blink_mask  1 = digit i blinks (only used with SEG_BLINK_EN)
//   AN          anode selects, active-low, at most one bit low
//   SEG         segments {g,f,e,d,c,b,a}, active-low
//   DP          decimal point, active-low
//   scan_tick   one-cycle pulse on each digit advance
// ---------------------------------------------------------------------------
module seg_scan_display #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  CP,
    input  logic                  reset,
    input  logic                  EN,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic                  scan_tick
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]     pre;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic              step;
    logic              blink_hide;

    logic [3:0]        nib;
    logic              dp_sel;
    logic [DIGITS-1:0] an_n;
    logic [6:0]        seg_dec;
    logic [6:0]        seg_n;
    logic              dp_n;

    // Step edge and the digit that becomes active on it
    always_comb begin
        step     = (pre == PRE_LAST);
        idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end

    // Prescaler and scan index
    always_ff @(posedge CP) begin
        if (reset) begin
            pre <= '0;
            idx <= IDX_LAST;
        end else if (step) begin
            pre <= '0;
            idx <= idx_next;
        end else begin
            pre <= pre + PW'(1);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Blink phase generator; phase 0 (visible) after reset
    always_ff @(posedge CP) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        blink_hide = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_next == IW'(i) && blink_mask[i] && phase) begin
                blink_hide = 1'b1;
            end
        end
    end
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;

    always_comb blink_hide = 1'b0;
`endif

    // Select the nibble, DP and anode of the digit about to be shown
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        an_n   = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                nib     = digits[4*i +: 4];
                dp_sel  = dp_mask[i];
                an_n[i] = 1'b0;
            end
        end

        unique case (nib)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase

        if (!EN) begin
            an_n  = '1;
            seg_n = 7'h7F;
            dp_n  = 1'b1;
        end else if (blink_hide) begin
            // Slot stays selected, only its content is blanked
            seg_n = 7'h7F;
            dp_n  = 1'b1;
        end else begin
            seg_n = seg_dec;
            dp_n  = ~dp_sel;
        end
    end

    // Registered pins; they only change on a step edge
    always_ff @(posedge CP) begin
        if (reset) begin
            AN        <= '1;
            SEG       <= 7'h7F;
            DP        <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= step;
            if (step) begin
                AN  <= an_n;
                SEG <= seg_n;
                DP  <= dp_n;
            end
        end
    end

endmodule
